// File: rtl/isa_vga_target.sv
// ISA-side bus target for the Zorro II bridge: 16x16 I/O register file with
// monitor-switch control, plus a memory window forwarded to SRAM via req/ack.
module isa_vga_target #(
    parameter int          ADDR_W      = 20,
    parameter logic [15:0] IO_BASE     = 16'h03C0,
    parameter logic [2:0]  MEM_BASE    = 3'b101,
    parameter int          MEM_WAIT    = 2,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] SA,
    input  logic              BALE,
    input  logic              IOR,
    input  logic              IOW,
    input  logic              MEMR,
    input  logic              MEMW,
    input  logic [15:0]       DG_IN,
    output logic [15:0]       DG_OUT,
    output logic              DG_OE,
    output logic              WAIT,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-4:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              MONISW,
    output logic              err
);

    localparam int CNT_W = (MEM_WAIT > 2) ? $clog2(MEM_WAIT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_IO_ACC, S_MEM_REQ, S_MEM_HOLD, S_ABORT, S_DONE, S_END
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [4:0]         r_sync [SYNC_STAGES];
    logic [ADDR_W-1:0]  r_sa;
    logic [15:0]        r_regs [16];
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ack_seen;
    logic               r_mem_write;
    logic               r_io_write;

    logic               w_bale_n;
    logic [3:0]         w_stb_n;
    logic [3:0]         w_stb;
    logic               w_multi;
    logic               w_io_hit;
    logic               w_mem_hit;
    logic               w_mem_stb_high;
    logic               w_release;
    logic [3:0]         w_idx;

    // Strobe bit order everywhere: {IOR, IOW, MEMR, MEMW}, all active low.
    always_ff @(posedge mclk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 5'h1F;
        end else begin
            r_sync[0] <= {BALE, IOR, IOW, MEMR, MEMW};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_bale_n       = r_sync[SYNC_STAGES-1][4];
    assign w_stb_n        = r_sync[SYNC_STAGES-1][3:0];
    assign w_stb          = ~w_stb_n;
    assign w_multi        = (w_stb & (w_stb - 4'd1)) != 4'd0;
    assign w_io_hit       = r_sa[15:5] == IO_BASE[15:5];
    assign w_mem_hit      = r_sa[ADDR_W-1 -: 3] == MEM_BASE;
    assign w_mem_stb_high = r_mem_write ? w_stb_n[0] : w_stb_n[1];
    assign w_release      = (r_cnt == '0) && (r_ack_seen || mem_ack);
    assign w_idx          = r_sa[4:1];
    assign MONISW         = r_regs[0][0];

    always_ff @(posedge mclk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_bale_n) w_next = S_ADDR;
            S_ADDR: begin
                if (w_multi)
                    w_next = S_DONE;
                else if (w_stb != 4'd0) begin
                    if ((w_stb[3] || w_stb[2]) && w_io_hit)
                        w_next = S_IO_ACC;
                    else if ((w_stb[1] || w_stb[0]) && w_mem_hit)
                        w_next = S_MEM_REQ;
                    else
                        w_next = S_DONE;
                end else if (w_bale_n)
                    w_next = S_IDLE;
            end
            S_IO_ACC: w_next = S_DONE;
            S_MEM_REQ, S_MEM_HOLD: begin
                // A released strobe is an abort; the SRAM request still runs to its ack.
                if (w_mem_stb_high)
                    w_next = (r_ack_seen || mem_ack) ? S_END : S_ABORT;
                else if (w_release)
                    w_next = S_DONE;
                else
                    w_next = S_MEM_HOLD;
            end
            S_ABORT:  if (mem_ack) w_next = S_END;
            S_DONE:   if (&w_stb_n) w_next = S_END;
            S_END:    if (w_bale_n) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_sa        <= '0;
            DG_OUT      <= '0;
            DG_OE       <= 1'b0;
            WAIT        <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            err         <= 1'b0;
            r_cnt       <= '0;
            r_ack_seen  <= 1'b0;
            r_mem_write <= 1'b0;
            r_io_write  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_next == S_ADDR) r_sa <= SA;
                S_ADDR: begin
                    if (w_multi) err <= 1'b1;
                    if (w_next == S_IO_ACC) r_io_write <= w_stb[2];
                    if (w_next == S_MEM_REQ) begin
                        WAIT        <= 1'b0;
                        mem_req     <= 1'b1;
                        mem_we      <= w_stb[0];
                        mem_addr    <= r_sa[ADDR_W-4:0];
                        mem_wdata   <= DG_IN;
                        r_cnt       <= CNT_W'(MEM_WAIT - 1);
                        r_ack_seen  <= 1'b0;
                        r_mem_write <= w_stb[0];
                    end
                end
                S_IO_ACC: begin
                    if (!r_io_write) begin
                        DG_OUT <= r_regs[w_idx];
                        DG_OE  <= 1'b1;
                    end else if (w_idx == 4'd15 && DG_IN[15]) begin
                        err <= 1'b0;
                    end
                end
                S_MEM_REQ, S_MEM_HOLD: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                    if (mem_ack) begin
                        r_ack_seen <= 1'b1;
                        mem_req    <= 1'b0;
                    end
                    if (w_next == S_END || w_next == S_ABORT) begin
                        WAIT  <= 1'b1;
                        DG_OE <= 1'b0;
                    end else begin
                        if (mem_ack && !r_mem_write) begin
                            DG_OUT <= mem_rdata;
                            DG_OE  <= 1'b1;
                        end
                        if (w_next == S_DONE) WAIT <= 1'b1;
                    end
                end
                S_ABORT: if (mem_ack) mem_req <= 1'b0;
                S_DONE:  if (w_next == S_END) DG_OE <= 1'b0;
                default: ;
            endcase
        end
    end

    // NOTE: the register file is reset like any other state because reg0 must
    // come up as 16'h0001 to select the Amiga display at power-on.
    always_ff @(posedge mclk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) r_regs[i] <= (i == 0) ? 16'h0001 : 16'h0000;
        end else if (r_state == S_IO_ACC && r_io_write) begin
            r_regs[w_idx] <= DG_IN;
        end
    end

endmodule

// File: tb/tb_isa_vga_target.sv
// Self-checking bench for isa_vga_target: transaction-level model of the
// register file / err flag, a bus-cycle driver with a simple SRAM responder.
module tb_isa_vga_target;

    localparam int MEM_WAIT = 2;

    logic        mclk;
    logic        reset;
    logic [19:0] SA;
    logic        BALE, IOR, IOW, MEMR, MEMW;
    logic [15:0] DG_IN;
    logic [15:0] DG_OUT;
    logic        DG_OE, WAIT, mem_req, mem_we;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        MONISW, err;

    isa_vga_target dut (
        .mclk(mclk), .reset(reset), .SA(SA), .BALE(BALE),
        .IOR(IOR), .IOW(IOW), .MEMR(MEMR), .MEMW(MEMW),
        .DG_IN(DG_IN), .DG_OUT(DG_OUT), .DG_OE(DG_OE), .WAIT(WAIT),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .MONISW(MONISW), .err(err)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: what the register file and sticky error flag must hold.
    logic [15:0] m_regs [16];
    logic        m_err;
    bit          m_busy = 1'b1;

    // Observations from the last bus cycle (cycle numbers count from BALE low).
    int          ob_wait_low, ob_wait_first, ob_wait_last;
    bit          ob_oe;
    int          ob_oe_first;
    logic [15:0] ob_dg;
    bit          ob_req, ob_req_stable;
    int          ob_req_first, ob_req_last, ob_ack_cyc, ob_rel;
    logic [16:0] ob_req_addr;
    logic        ob_req_we;
    logic [15:0] ob_req_wdata;
    bit          ob_timeout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge mclk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        m_regs[0] = 16'h0001;
        m_err = 1'b0;
    endtask

    // Between bus cycles the target must be quiet and reflect the model.
    always @(negedge mclk) begin
        if (!reset && !m_busy)
            check("idle_outputs", {27'd0, MONISW, err, DG_OE, WAIT, mem_req},
                  {27'd0, m_regs[0][0], m_err, 1'b0, 1'b1, 1'b0});
    end

    // stb bits: {IOR, IOW, MEMR, MEMW}, 1 = drive that strobe low.
    task automatic bus_cycle(input logic [19:0] addr, input logic [3:0] stb,
                             input logic [15:0] wdata, input int hold,
                             input int ack_delay, input logic [15:0] rdata,
                             input bit abort);
        int cyc;
        int bale_cyc;
        bit released;
        ob_wait_low = 0; ob_wait_first = -1; ob_wait_last = -1;
        ob_oe = 0; ob_oe_first = -1; ob_dg = '0;
        ob_req = 0; ob_req_stable = 1; ob_req_first = -1; ob_req_last = -1;
        ob_req_addr = '0; ob_req_we = 0; ob_req_wdata = '0;
        ob_ack_cyc = -1; ob_rel = -1; ob_timeout = 0;
        released = 0; bale_cyc = -1;
        SA = addr; DG_IN = wdata; BALE = 1'b0;
        cyc = 0;
        while (1) begin
            if (!WAIT) begin
                ob_wait_low++;
                if (ob_wait_first < 0) ob_wait_first = cyc;
                ob_wait_last = cyc;
            end
            if (DG_OE && !ob_oe) begin
                ob_oe = 1; ob_oe_first = cyc; ob_dg = DG_OUT;
            end
            if (mem_req) begin
                if (!ob_req) begin
                    ob_req = 1; ob_req_first = cyc;
                    ob_req_addr = mem_addr; ob_req_we = mem_we; ob_req_wdata = mem_wdata;
                end else if ({mem_addr, mem_we, mem_wdata} != {ob_req_addr, ob_req_we, ob_req_wdata}) begin
                    ob_req_stable = 0;
                end
                ob_req_last = cyc;
            end
            mem_ack = 1'b0;
            if (bale_cyc >= 0 && cyc >= bale_cyc + 6 && (!ob_req || (ob_ack_cyc >= 0 && ob_ack_cyc < cyc)))
                break;
            if (cyc >= 400) begin
                ob_timeout = 1;
                break;
            end
            if (ob_req && ack_delay >= 0 && cyc == ob_req_first + ack_delay) begin
                mem_ack = 1'b1; mem_rdata = rdata; ob_ack_cyc = cyc;
            end
            if (cyc == 2) begin
                {IOR, IOW, MEMR, MEMW} = ~stb;
            end else if (cyc > 2 && !released && cyc - 2 >= hold && (abort || WAIT)) begin
                {IOR, IOW, MEMR, MEMW} = 4'hF;
                released = 1; ob_rel = cyc;
            end
            if (released && cyc == ob_rel + 4) begin
                BALE = 1'b1; bale_cyc = cyc;
            end
            tick();
            cyc++;
        end
        {IOR, IOW, MEMR, MEMW} = 4'hF;
        BALE = 1'b1;
        mem_ack = 1'b0;
    endtask

    // Runs one bus cycle, compares against the model's prediction, updates model.
    task automatic run(input string name, input logic [19:0] addr, input logic [3:0] stb,
                       input logic [15:0] wdata, input int hold, input int ack_delay,
                       input logic [15:0] rdata, input bit abort);
        int          n;
        bit          io_hit, mem_hit, exp_req, exp_oe;
        logic [15:0] exp_dg;
        logic [3:0]  idx;
        m_busy  = 1;
        n       = $countones(stb);
        io_hit  = (addr[15:5] == 11'h01E);
        mem_hit = (addr[19:17] == 3'b101);
        idx     = addr[4:1];
        exp_req = (n == 1) && (stb[1] || stb[0]) && mem_hit;
        exp_oe  = (n == 1) && ((stb[3] && io_hit) || (stb[1] && mem_hit && !abort));
        exp_dg  = stb[3] ? m_regs[idx] : rdata;
        bus_cycle(addr, stb, wdata, hold, ack_delay, rdata, abort);
        check({name, "_timeout"}, 32'(ob_timeout), 32'd0);
        check({name, "_oe"}, 32'(ob_oe), 32'(exp_oe));
        if (exp_oe) check({name, "_dg"}, 32'(ob_dg), 32'(exp_dg));
        check({name, "_req"}, 32'(ob_req), 32'(exp_req));
        check({name, "_wait_drop"}, 32'(ob_wait_low != 0), 32'(exp_req));
        if (exp_req) begin
            check({name, "_addr"}, 32'(ob_req_addr), 32'(addr[16:0]));
            check({name, "_we"}, 32'(ob_req_we), 32'(stb[0]));
            if (stb[0]) check({name, "_wdata"}, 32'(ob_req_wdata), 32'(wdata));
            check({name, "_req_stable"}, 32'(ob_req_stable), 32'd1);
            check({name, "_req_until_ack"}, ob_req_last, ob_ack_cyc);
            check({name, "_wait_with_req"}, ob_wait_first, ob_req_first);
            if (!abort) check({name, "_wait_min"}, 32'(ob_wait_low >= MEM_WAIT), 32'd1);
        end
        if (n > 1) m_err = 1'b1;
        if (n == 1 && stb[2] && io_hit) begin
            m_regs[idx] = wdata;
            if (idx == 4'd15 && wdata[15]) m_err = 1'b0;
        end
        tick();
        m_busy = 0;
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; SA = '0; BALE = 1'b1;
        {IOR, IOW, MEMR, MEMW} = 4'hF;
        DG_IN = '0; mem_rdata = '0; mem_ack = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_outputs", {25'd0, WAIT, DG_OE, mem_req, mem_we, MONISW, err, 1'b0},
              {25'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        check("rst_dg_out", 32'(DG_OUT), 32'h0);
        reset = 1'b0;
        repeat (3) tick();
        m_busy = 0;
        repeat (2) tick();

        // I/O register write then read back
        run("iow_reg1", 20'h003C2, 4'b0100, 16'hA5A5, 10, -1, 16'h0, 0);
        run("ior_reg1", 20'h003C2, 4'b1000, 16'h0000, 10, -1, 16'h0, 0);
        check("ior_reg1_lit", 32'(ob_dg), 32'h0000A5A5);
        check("ior_latency", 32'(ob_oe_first - 2 <= 5), 32'd1);

        // Monitor switch and an I/O window miss
        run("iow_reg0_0", 20'h003C0, 4'b0100, 16'h0000, 10, -1, 16'h0, 0);
        check("monisw_vga", 32'(MONISW), 32'd0);
        run("iow_reg0_1", 20'h003C0, 4'b0100, 16'h0001, 10, -1, 16'h0, 0);
        check("monisw_amiga", 32'(MONISW), 32'd1);
        run("iow_miss", 20'h003E0, 4'b0100, 16'h0000, 10, -1, 16'h0, 0);
        run("ior_miss", 20'h003E2, 4'b1000, 16'h0000, 10, -1, 16'h0, 0);
        run("iow_reg2", 20'h003C4, 4'b0100, 16'h5A5A, 10, -1, 16'h0, 0);
        run("ior_reg2", 20'h003C4, 4'b1000, 16'h0000, 10, -1, 16'h0, 0);
        check("ior_reg2_lit", 32'(ob_dg), 32'h00005A5A);

        // Memory read, ack five cycles after the request
        run("memr", 20'hA0010, 4'b0010, 16'h0000, 10, 5, 16'h1234, 0);
        check("memr_dg_lit", 32'(ob_dg), 32'h00001234);
        check("memr_addr_lit", 32'(ob_req_addr), 32'h00010);
        check("memr_wait_cycles", ob_wait_low, 32'd6);
        check("memr_wait_rise", ob_wait_last, ob_ack_cyc);

        // Memory write, ack in the very first request cycle
        run("memw", 20'hBFFFE, 4'b0001, 16'hC3C3, 10, 0, 16'h0, 0);
        check("memw_addr_lit", 32'(ob_req_addr), 32'h1FFFE);
        check("memw_wait_cycles", ob_wait_low, 32'd2);

        // Memory window miss and a double strobe
        run("memr_miss", 20'h80010, 4'b0010, 16'h0000, 10, 0, 16'h0, 0);
        run("multi", 20'hA0010, 4'b1010, 16'h0000, 10, 0, 16'h0, 0);
        check("multi_err_lit", 32'(err), 32'd1);
        run("clr_err", 20'h003DE, 4'b0100, 16'h8000, 10, -1, 16'h0, 0);
        check("clr_err_lit", 32'(err), 32'd0);

        // Strobe released before ack: abort, request still completes
        run("abort", 20'hA0010, 4'b0010, 16'h0000, 5, 8, 16'hDEAD, 1);
        check("abort_wait_rise", ob_wait_last, ob_rel + 2);
        run("post_abort_ior", 20'h003C2, 4'b1000, 16'h0000, 10, -1, 16'h0, 0);
        check("post_abort_lit", 32'(ob_dg), 32'h0000A5A5);

        // Reset in the middle of a stretched memory cycle
        run("pre_rst_reg0", 20'h003C0, 4'b0100, 16'h0000, 10, -1, 16'h0, 0);
        run("pre_rst_err", 20'h003C2, 4'b1100, 16'h0000, 10, -1, 16'h0, 0);
        m_busy = 1;
        SA = 20'hA0010; BALE = 1'b0;
        repeat (2) tick();
        MEMR = 1'b0;
        repeat (6) tick();
        check("hold_before_rst", {30'd0, WAIT, mem_req}, {30'd0, 1'b0, 1'b1});
        reset = 1'b1;
        tick();
        check("midrst_outputs", {25'd0, WAIT, DG_OE, mem_req, mem_we, MONISW, err, 1'b0},
              {25'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        check("midrst_dg_out", 32'(DG_OUT), 32'h0);
        MEMR = 1'b1; BALE = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        model_reset();
        repeat (3) tick();
        m_busy = 0;
        repeat (2) tick();
        run("post_rst_reg1", 20'h003C2, 4'b1000, 16'h0000, 10, -1, 16'h0, 0);
        check("post_rst_reg1_lit", 32'(ob_dg), 32'h0);
        run("post_rst_reg0", 20'h003C0, 4'b1000, 16'h0000, 10, -1, 16'h0, 0);
        check("post_rst_reg0_lit", 32'(ob_dg), 32'h0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
